// File: rtl/aes_pkg.sv
// ============================================================================
// Module   : aes_pkg
// Purpose  : Shared constants, types and helpers for the iterative AES-128
//            engine: round count, rcon table, FSM state encoding,
//            UNROLL legality check, rcon lookup and GF(2^8) xtime.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_pkg;

  localparam int AES_NR = 10;

  // Round constants, indexed by round number 1..10.
  localparam logic [7:0] AES_RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic [1:0] {
    AES_IDLE = 2'd0,
    AES_RUN  = 2'd1,
    AES_DONE = 2'd2
  } aes_fsm_e;

  // Only divisors of the round count give a whole number of compute cycles.
  function automatic bit aes_unroll_legal(input int unroll);
    return (unroll == 1) || (unroll == 2) || (unroll == 5) || (unroll == 10);
  endfunction

  // Out-of-range rounds (chain copies idling outside RUN) read back zero.
  function automatic logic [7:0] aes_rcon(input logic [3:0] rnd);
    if ((rnd >= 4'd1) && (rnd <= 4'd10)) begin
      return AES_RCON[rnd];
    end
    return 8'h00;
  endfunction

  function automatic logic [7:0] aes_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_round_comb.sv
// ============================================================================
// Module   : aes_round_comb
// Purpose  : One complete AES-128 round, purely combinational. Derives the
//            next round key from the current one and applies SubBytes,
//            ShiftRows, MixColumns (skipped when last) and AddRoundKey.
// Ports    : s      [127:0] in  - state entering the round
//            k      [127:0] in  - previous round key
//            rcon   [7:0]   in  - round constant for this round
//            last           in  - final round, MixColumns bypassed
//            s_next [127:0] out - state leaving the round
//            k_next [127:0] out - round key used by this round
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_round_comb
  import aes_pkg::*;
(
  input  logic [127:0] s,
  input  logic [127:0] k,
  input  logic [7:0]   rcon,
  input  logic         last,
  output logic [127:0] s_next,
  output logic [127:0] k_next
);

  logic [7:0]  sb [16];
  logic [7:0]  sr [16];
  logic [7:0]  mc [16];
  logic [31:0] rot_word;
  logic [31:0] sub_word;
  logic [31:0] key_tmp;
  logic [31:0] w0_n;
  logic [31:0] w1_n;
  logic [31:0] w2_n;
  logic [31:0] w3_n;

  // SubBytes on the sixteen state bytes; byte i sits at [127-8i -: 8].
  for (genvar i = 0; i < 16; i++) begin : g_state_sbox
    aes_sbox u_sbox (
      .a (s[127-8*i -: 8]),
      .d (sb[i])
    );
  end

  // Key schedule: RotWord of the last word, then SubWord.
  assign rot_word = {k[23:0], k[31:24]};

  for (genvar j = 0; j < 4; j++) begin : g_key_sbox
    aes_sbox u_sbox (
      .a (rot_word[31-8*j -: 8]),
      .d (sub_word[31-8*j -: 8])
    );
  end

  assign key_tmp = sub_word ^ {rcon, 24'h000000};
  assign w0_n    = k[127:96] ^ key_tmp;
  assign w1_n    = k[95:64]  ^ w0_n;
  assign w2_n    = k[63:32]  ^ w1_n;
  assign w3_n    = k[31:0]   ^ w2_n;
  assign k_next  = {w0_n, w1_n, w2_n, w3_n};

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        // Row r rotates left by r columns.
        sr[4*c+r] = sb[4*((c+r)%4)+r];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      mc[4*c+0] = aes_xtime(sr[4*c+0]) ^ aes_xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c+0] ^ aes_xtime(sr[4*c+1]) ^ aes_xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c+0] ^ sr[4*c+1] ^ aes_xtime(sr[4*c+2]) ^ aes_xtime(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = aes_xtime(sr[4*c+0]) ^ sr[4*c+0] ^ sr[4*c+1] ^ sr[4*c+2] ^ aes_xtime(sr[4*c+3]);
    end
  end

  always_comb begin
    s_next = '0;
    for (int i = 0; i < 16; i++) begin
      s_next[127-8*i -: 8] = (last ? sr[i] : mc[i]) ^ k_next[127-8*i -: 8];
    end
  end

endmodule

`default_nettype wire

// File: rtl/aes_sbox.sv
// ============================================================================
// Module   : aes_sbox
// Purpose  : AES forward S-box as a constant lookup table.
// Ports    : a [7:0] in  - input byte
//            d [7:0] out - substituted byte
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] d
);

  // Entry 0x00 sits in the top byte; entry n lives at bits 8*(255-n)+7 -: 8.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777b_f26b6fc5_3001672b_fed7ab76,
    128'hca82c97d_fa5947f0_add4a2af_9ca472c0,
    128'hb7fd9326_363ff7cc_34a5e5f1_71d83115,
    128'h04c723c3_1896059a_071280e2_eb27b275,
    128'h09832c1a_1b6e5aa0_523bd6b3_29e32f84,
    128'h53d100ed_20fcb15b_6acbbe39_4a4c58cf,
    128'hd0efaafb_434d3385_45f9027f_503c9fa8,
    128'h51a3408f_929d38f5_bcb6da21_10fff3d2,
    128'hcd0c13ec_5f974417_c4a77e3d_645d1973,
    128'h60814fdc_222a9088_46eeb814_de5e0bdb,
    128'he0323a0a_4906245c_c2d3ac62_9195e479,
    128'he7c8376d_8dd54ea9_6c56f4ea_657aae08,
    128'hba78252e_1ca6b4c6_e8dd741f_4bbd8b8a,
    128'h703eb566_4803f60e_613557b9_86c11d9e,
    128'he1f89811_69d98e94_9b1e87e9_ce5528df,
    128'h8ca1890d_bfe64268_41992d0f_b054bb16
  };

  assign d = SBOX_TABLE[{~a, 3'b111} -: 8];

endmodule

`default_nettype wire

// File: rtl/aes_128_iter.sv
// ============================================================================
// Module   : aes_128_iter
// Purpose  : Iterative AES-128 encryption engine with valid/ready handshakes.
//            Executes UNROLL rounds per clock (UNROLL in {1,2,5,10}) with an
//            on-the-fly key schedule; one block in flight at a time.
// Ports    : clk             in  - clock, rising edge
//            rst             in  - asynchronous reset, active low
//            in_valid        in  - block presented on state/key
//            in_ready        out - block can be accepted this cycle
//            state   [127:0] in  - plaintext, byte 0 at [127:120]
//            key     [127:0] in  - cipher key, same ordering
//            out_valid       out - out holds a finished ciphertext
//            out_ready       in  - consumer takes out this cycle
//            out     [127:0] out - ciphertext, stable while stalled
//            blk_cnt [31:0]  out - output transfers, wraps (macro only)
//            busy_cyc[31:0]  out - cycles spent in RUN, saturates (macro only)
// Macro    : AES_128_ITER_CNT_EN adds the blk_cnt / busy_cyc counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_128_iter
  import aes_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out
`ifdef AES_128_ITER_CNT_EN
  ,
  output logic [31:0]  blk_cnt,
  output logic [31:0]  busy_cyc
`endif
);

  localparam int NCYC = AES_NR / UNROLL;

  localparam logic [1:0] FSM_IDLE = AES_IDLE;
  localparam logic [1:0] FSM_RUN  = AES_RUN;
  localparam logic [1:0] FSM_DONE = AES_DONE;

  // Round number at which the cycle containing round 10 begins.
  localparam logic [3:0] RND_LAST_CYC = 4'(AES_NR + 1 - UNROLL);

  if (!aes_unroll_legal(UNROLL)) begin : g_bad_unroll
    $error("aes_128_iter: UNROLL=%0d is illegal, use 1, 2, 5 or 10", UNROLL);
  end

  logic [1:0]   fsm_q,       fsm_d;
  logic [127:0] s_q,         s_d;
  logic [127:0] k_q,         k_d;
  logic [3:0]   rnd_q,       rnd_d;
  logic [127:0] out_q,       out_d;
  logic         out_valid_q, out_valid_d;

  logic         in_xfer;
  logic         last_cyc;
  logic [127:0] s_ch [UNROLL+1];
  logic [127:0] k_ch [UNROLL+1];

  assign s_ch[0] = s_q;
  assign k_ch[0] = k_q;

  // Round chain: copy u executes round rnd_q+u within the current cycle.
  for (genvar u = 0; u < UNROLL; u++) begin : g_round
    logic [3:0] rnd_u;
    assign rnd_u = rnd_q + 4'(u);

    aes_round_comb u_round (
      .s      (s_ch[u]),
      .k      (k_ch[u]),
      .rcon   (aes_rcon(rnd_u)),
      .last   (rnd_u == 4'(AES_NR)),
      .s_next (s_ch[u+1]),
      .k_next (k_ch[u+1])
    );
  end

  assign in_ready = (fsm_q == FSM_IDLE) | ((fsm_q == FSM_DONE) & out_ready);
  assign in_xfer  = in_valid & in_ready;
  assign last_cyc = (rnd_q == RND_LAST_CYC);

  always_comb begin
    fsm_d       = fsm_q;
    s_d         = s_q;
    k_d         = k_q;
    rnd_d       = rnd_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;

    case (fsm_q)
      FSM_RUN: begin
        s_d = s_ch[UNROLL];
        k_d = k_ch[UNROLL];
        if (last_cyc) begin
          out_d       = s_ch[UNROLL];
          out_valid_d = 1'b1;
          rnd_d       = 4'd0;
          fsm_d       = FSM_DONE;
        end else begin
          rnd_d = rnd_q + 4'(UNROLL);
        end
      end
      FSM_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          fsm_d       = FSM_IDLE;
        end
      end
      FSM_IDLE: begin
        fsm_d = FSM_IDLE;
      end
      default: begin
        fsm_d = FSM_IDLE;
      end
    endcase

    // An accepted block overrides IDLE/DONE handling, which lets a new block
    // start in the same cycle the previous result is consumed.
    if (in_xfer) begin
      s_d   = state ^ key;
      k_d   = key;
      rnd_d = 4'd1;
      fsm_d = FSM_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q       <= FSM_IDLE;
      s_q         <= '0;
      k_q         <= '0;
      rnd_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      s_q         <= s_d;
      k_q         <= k_d;
      rnd_q       <= rnd_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;

`ifdef AES_128_ITER_CNT_EN
  logic [31:0] blk_cnt_q,  blk_cnt_d;
  logic [31:0] busy_cyc_q, busy_cyc_d;

  always_comb begin
    blk_cnt_d  = blk_cnt_q;
    busy_cyc_d = busy_cyc_q;
    if (out_valid_q & out_ready) begin
      blk_cnt_d = blk_cnt_q + 32'd1;
    end
    if ((fsm_q == FSM_RUN) && (busy_cyc_q != 32'hFFFF_FFFF)) begin
      busy_cyc_d = busy_cyc_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blk_cnt_q  <= '0;
      busy_cyc_q <= '0;
    end else begin
      blk_cnt_q  <= blk_cnt_d;
      busy_cyc_q <= busy_cyc_d;
    end
  end

  assign blk_cnt  = blk_cnt_q;
  assign busy_cyc = busy_cyc_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_aes_128_iter.sv
// ============================================================================
// Module   : tb_aes_128_iter
// Purpose  : Self-checking bench for aes_128_iter. Four engines with UNROLL
//            1/2/5/10 share clock and reset; expected ciphertexts are queued
//            on acceptance and compared when each engine presents output.
// Macro    : AES_128_ITER_CNT_EN enables the counter checks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_128_iter;

  localparam int ND = 4;

  localparam logic [127:0] FIPS_K = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] FIPS_S = 128'h3243f6a8_885a308d_313198a2_e0370734;
  localparam logic [127:0] FIPS_O = 128'h3925841d_02dc09fb_dc118597_196a0b32;
  localparam logic [127:0] APPC_K = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [127:0] APPC_S = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] APPC_O = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
  localparam logic [127:0] ZERO_O = 128'h66e94bd4_ef8a2c3b_884cfa59_ca342b2e;
  localparam logic [127:0] ONE_O  = 128'h58e2fcce_fa7e3061_367f1d57_a4e7455a;

  function automatic int un_of(input int d);
    case (d)
      0:       return 1;
      1:       return 2;
      2:       return 5;
      default: return 10;
    endcase
  endfunction

  function automatic int ncyc_of(input int d);
    return 10 / un_of(d);
  endfunction

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [ND-1:0] in_valid;
  logic [ND-1:0] in_ready;
  logic [ND-1:0] out_valid;
  logic [ND-1:0] out_ready;
  logic [127:0]  st_in  [ND];
  logic [127:0]  key_in [ND];
  logic [127:0]  dout   [ND];
`ifdef AES_128_ITER_CNT_EN
  logic [31:0]   blk_cnt  [ND];
  logic [31:0]   busy_cyc [ND];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int UNV = un_of(g);
    aes_128_iter #(.UNROLL(UNV)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .state     (st_in[g]),
      .key       (key_in[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out       (dout[g])
`ifdef AES_128_ITER_CNT_EN
      ,
      .blk_cnt   (blk_cnt[g]),
      .busy_cyc  (busy_cyc[g])
`endif
    );
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (byte-oriented FIPS-197) ----------------
  logic [7:0] sbx [256];

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] a;
    logic [7:0] b;
    logic       hi;
    p = 8'h00; a = x; b = y;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      b = inv;
      sbx[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] s);
    logic [7:0]   a  [16];
    logic [7:0]   t  [16];
    logic [7:0]   rk [16];
    logic [7:0]   tw [4];
    logic [7:0]   rc;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) begin
      rk[i] = k[127-8*i -: 8];
      a[i]  = s[127-8*i -: 8] ^ rk[i];
    end
    for (int rd = 1; rd <= 10; rd++) begin
      tw[0] = sbx[rk[13]] ^ rc;
      tw[1] = sbx[rk[14]];
      tw[2] = sbx[rk[15]];
      tw[3] = sbx[rk[12]];
      for (int j = 0; j < 4; j++) rk[j] = rk[j] ^ tw[j];
      for (int i = 4; i < 16; i++) rk[i] = rk[i] ^ rk[i-4];
      rc = gmul(rc, 8'h02);
      for (int i = 0; i < 16; i++) t[i] = sbx[a[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          a[4*c+row] = t[4*((c+row)%4)+row];
      if (rd != 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int j = 0; j < 4; j++) t[j] = a[4*c+j];
          for (int j = 0; j < 4; j++)
            a[4*c+j] = gmul(t[j], 8'h02) ^ gmul(t[(j+1)%4], 8'h03) ^ t[(j+2)%4] ^ t[(j+3)%4];
        end
      end
      for (int i = 0; i < 16; i++) a[i] = a[i] ^ rk[i];
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = a[i];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    int           d;
    logic [127:0] data;
    int           acc;
  } exp_t;

  exp_t          sb_q [$];
  logic [ND-1:0] seen;

  // Inputs change only just after a rising edge, so what is visible on the
  // falling edge is exactly what the next rising edge will act on.
  always @(negedge clk) begin
    if (!rst) begin
      seen = '0;
    end else begin
      for (int d = 0; d < ND; d++) begin
        if (out_valid[d]) begin
          if ((sb_q.size() == 0) || (sb_q[0].d != d)) begin
            chk($sformatf("spurious_valid_u%0d", un_of(d)), out_valid[d], 1'b0);
          end else begin
            if (!seen[d]) begin
              chk($sformatf("latency_u%0d", un_of(d)), 128'(cyc - sb_q[0].acc), 128'(ncyc_of(d)));
              chk($sformatf("data_u%0d", un_of(d)), dout[d], sb_q[0].data);
              seen[d] = 1'b1;
            end else begin
              chk($sformatf("hold_u%0d", un_of(d)), dout[d], sb_q[0].data);
            end
            if (out_ready[d]) begin
              void'(sb_q.pop_front());
              seen[d] = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic send(input int d, input logic [127:0] k, input logic [127:0] s,
                      input logic [127:0] e, output int acc);
    bit   ok;
    exp_t ent;
    ok = 1'b0;
    acc = -1;
    key_in[d]   = k;
    st_in[d]    = s;
    in_valid[d] = 1'b1;
    for (int t = 0; (t < 200) && !ok; t++) begin
      @(negedge clk);
      if (in_ready[d]) begin
        ok       = 1'b1;
        acc      = cyc + 1;
        ent.d    = d;
        ent.data = e;
        ent.acc  = acc;
        sb_q.push_back(ent);
      end
    end
    if (!ok) chk("accept_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
    key_in[d]   = rnd128();
    st_in[d]    = rnd128();
  endtask

  task automatic drain();
    for (int t = 0; (t < 400) && (sb_q.size() != 0); t++) @(negedge clk);
    if (sb_q.size() != 0) begin
      chk("drain_timeout", 128'(sb_q.size()), 128'd0);
      sb_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out_valid(input int d);
    bit got;
    got = 1'b0;
    for (int t = 0; (t < 100) && !got; t++) begin
      @(negedge clk);
      if (out_valid[d]) got = 1'b1;
    end
    if (!got) chk("out_valid_timeout", 1'b0, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc;
    int prev;
    int nb;
    logic [127:0] k;
    logic [127:0] s;
`ifdef AES_128_ITER_CNT_EN
    logic [31:0] blk0;
    logic [31:0] busy0;
`endif

    in_valid  = '0;
    out_ready = '1;
    for (int d = 0; d < ND; d++) begin
      st_in[d]  = '0;
      key_in[d] = '0;
    end

    build_sbox();
    chk("model_fips", aes_ref(FIPS_K, FIPS_S), FIPS_O);

    // Reset state
    #22;
    chk("rst_out_valid", out_valid, 4'h0);
    chk("rst_in_ready", in_ready, 4'hf);
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("rst_out_u%0d", un_of(d)), dout[d], 128'd0);
`ifdef AES_128_ITER_CNT_EN
      chk($sformatf("rst_blk_cnt_u%0d", un_of(d)), blk_cnt[d], 32'd0);
      chk($sformatf("rst_busy_cyc_u%0d", un_of(d)), busy_cyc[d], 32'd0);
`endif
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("rel_in_ready", in_ready, 4'hf);

    // FIPS-197 vector on UNROLL=1
    send(0, FIPS_K, FIPS_S, FIPS_O, acc);
    drain();

    // UNROLL sweep with the appendix C vector
    for (int d = 0; d < ND; d++) begin
      send(d, APPC_K, APPC_S, APPC_O, acc);
      drain();
    end

    // Back-pressure on UNROLL=1; the second block waits on in_valid meanwhile
    out_ready[0] = 1'b0;
    send(0, 128'd0, 128'd0, ZERO_O, acc);
    key_in[0]   = 128'd0;
    st_in[0]    = 128'd1;
    in_valid[0] = 1'b1;
    wait_out_valid(0);
    for (int t = 0; t < 7; t++) begin
      chk("bp_in_ready", in_ready[0], 1'b0);
      chk("bp_out_stable", dout[0], ZERO_O);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready[0] = 1'b1;
    send(0, 128'd0, 128'd1, ONE_O, acc);
    drain();

    // Streaming random blocks, out_ready held high
    for (int d = 0; d < ND; d++) begin
      nb   = (d == 0) ? 20 : 5;
      prev = 0;
      for (int b = 0; b < nb; b++) begin
        k = rnd128();
        s = rnd128();
        send(d, k, s, aes_ref(k, s), acc);
        if (b > 0) chk($sformatf("period_u%0d", un_of(d)), 128'(acc - prev), 128'(ncyc_of(d) + 1));
        prev = acc;
      end
      drain();
    end

    // Reset with UNROLL=2 stalled in DONE and UNROLL=1 mid-block at rnd=4
    out_ready[1] = 1'b0;
    send(1, 128'd0, 128'd0, ZERO_O, acc);
    wait_out_valid(1);
    @(posedge clk);
    #1;
    send(0, FIPS_K, FIPS_S, FIPS_O, acc);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_async_out_valid", out_valid, 4'h0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst          = 1'b1;
    out_ready[1] = 1'b1;
    chk("rst_rel_in_ready", in_ready, 4'hf);
    repeat (12) @(posedge clk);
    #1;
    chk("rst_no_stale", out_valid, 4'h0);
    send(0, FIPS_K, FIPS_S, FIPS_O, acc);
    drain();

`ifdef AES_128_ITER_CNT_EN
    blk0  = blk_cnt[1];
    busy0 = busy_cyc[1];
    for (int b = 0; b < 3; b++) begin
      k = rnd128();
      s = rnd128();
      send(1, k, s, aes_ref(k, s), acc);
    end
    drain();
    chk("blk_cnt_delta", blk_cnt[1] - blk0, 32'd3);
    chk("busy_cyc_delta", busy_cyc[1] - busy0, 32'd15);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/aes_128_iter.md
Name: aes_128_iter

Overview:
- Iterative, parametrised AES-128 encryption engine with valid/ready handshakes on input and output.
- Processes one block at a time and executes UNROLL rounds per clock, trading area against latency.
- Generates the key schedule on the fly, so no expanded-key storage is needed.
- Sits beside the fully pipelined aes_128 core, for area-constrained instances and for cores that need back-pressure.

Parameters:
- UNROLL, 1, rounds executed per clock; legal values are 1, 2, 5 and 10; any other value is an elaboration-time error.
- NCYC, 10/UNROLL, derived localparam (not overridable); number of compute cycles per block.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-low: asserting rst=0 clears all state immediately.
- in_valid  input  1  a new block is presented on state/key.
- in_ready  output  1  the engine can accept a block this cycle.
- state  input  128  plaintext, byte 0 at [127:120] (same ordering as aes_128).
- key  input  128  cipher key, same byte ordering.
- out_valid  output  1  out holds a completed ciphertext.
- out_ready  input  1  the consumer accepts out this cycle.
- out  output  128  ciphertext, held stable while out_valid=1 and out_ready=0.

Behaviour:
- FSM states: IDLE, RUN, DONE. Reset values: IDLE; in_ready=1 once rst is released; out_valid=0; out=0; round counter=0; working state and key registers=0.
- in_ready = (fsm==IDLE) | (fsm==DONE & out_ready).
- An input transfer happens when in_valid & in_ready at a rising edge.
- On an input transfer: s <= state ^ key (round-0 AddRoundKey), k <= key, rnd <= 1, fsm <= RUN.
- RUN, each cycle:
  - Apply UNROLL consecutive rounds rnd .. rnd+UNROLL-1.
  - Each round first derives round key i from the previous round key (RotWord, SubWord, XOR rcon[i]), then applies it.
  - rcon = 01,02,04,08,10,20,40,80,1b,36.
  - Rounds 1..9 are SubBytes, ShiftRows, MixColumns, AddRoundKey. Round 10 omits MixColumns.
  - rnd advances by UNROLL; it is 4 bits and never exceeds 10.
- When the cycle that includes round 10 completes: out <= result, out_valid <= 1, fsm <= DONE.
- DONE:
  - out_valid stays high and out is held until out_ready=1.
  - On out_ready without a new input transfer: out_valid <= 0, fsm <= IDLE. out keeps its last value; it is don't-care once out_valid=0.
  - Output transfer and input transfer in the same cycle: the new block is accepted, out_valid <= 0, fsm <= RUN. No bubble beyond the DONE cycle.
- Latency: out_valid rises exactly NCYC rising edges after the accepting edge.
- Throughput with out_ready held at 1: one block every NCYC+1 cycles.
- state and key are sampled only at the accepting edge; they may change freely afterwards.
- in_valid while busy (RUN, or DONE without out_ready) is ignored; the source must hold it until in_ready.
- Reset asserted mid-block: the block is discarded, out_valid drops asynchronously, and no stale output appears after release.
- out_ready is ignored outside DONE.

Optional Feature:
- Macro: AES_128_ITER_CNT_EN.
- Defined:
  - Adds output blk_cnt [31:0], reset to 0.
  - Increments on every output transfer (out_valid & out_ready) and wraps modulo 2^32.
  - Also adds output busy_cyc [31:0], reset to 0, incremented every cycle fsm==RUN, saturating at 32'hFFFF_FFFF.
- Not defined: neither port exists and there are no counter registers. Datapath timing is identical in both builds.

Decomposition:
- Package aes_pkg holds:
  - AES_NR=10
  - the rcon table as a constant array indexed 1..10
  - the FSM state enum (IDLE/RUN/DONE)
  - the legal-UNROLL check function.
- One sub-module, aes_round_comb, is purely combinational.
  - Inputs: s[127:0], k[127:0], rcon[7:0], last.
  - Outputs: s_next, k_next.
  - It reuses the existing S-box table modules.
  - aes_128_iter instantiates UNROLL copies in a chain.
  - last is asserted only on the copy executing round 10.

Test Plan:
- FIPS-197 vector, UNROLL=1: key 2b7e1516_28aed2a6_abf71588_09cf4f3c, state 3243f6a8_885a308d_313198a2_e0370734 → out_valid exactly 10 edges after acceptance, out=3925841d02dc09fbdc118597196a0b32.
- UNROLL sweep 1/2/5/10: key 000102..0f, state 00112233..eeff → out=69c4e0d86a7b0430d8cdb78070b4c55a after 10/5/2/1 cycles respectively.
- Back-pressure: key=0, state=0, hold out_ready=0 for 7 cycles → out=66e94bd4ef8a2c3b884cfa59ca342b2e stable and in_ready=0 throughout. Raise out_ready together with in_valid → the second block is accepted in the same cycle and its result (key=0, state=1: 58e2fcce fa7e3061 367f1d57 a4e7455a) follows after NCYC edges.
- Streaming, out_ready=1, the 20 random key/state pairs used for the aes_128 regression → outputs match the aes_128 results in order, with one block every NCYC+1 cycles.
- Reset at rnd=4 (UNROLL=1) → out_valid=0 immediately, in_ready=1 after release. A fresh FIPS-197 block then completes correctly.
- With AES_128_ITER_CNT_EN defined, 3 blocks at UNROLL=2 → blk_cnt=3 and busy_cyc=15.
